bus_share_arbiter: RTL

- Round-robin arbiter that shares one SIZE-bit datapath bus among NREQ requesters.
- Each cycle it selects the granted requester's data word, registers it onto the shared output, and flags it valid.
- Sits between the register-file/ALU operand sources and the shared internal bus. It replaces hard-wired 2:1 select lines with a sequenced, fair owner select.

---
 rtl/bus_share_arbiter_if.sv | 26 ++
 rtl/bus_share_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/bus_share_arbiter_if.sv
// Shared-bus arbiter handshake bundle: requester side (master)
// drives req/din, arbiter side (slave) returns grant and bus data.
interface bus_share_arbiter_if #(
    parameter int SIZE = 8,
    parameter int NREQ = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] din;
    logic [NREQ-1:0]      grant;
    logic [IW-1:0]        grant_idx;
    logic [SIZE-1:0]      dout;
    logic                 dout_valid;
    logic                 busy;

    modport master (
        output req, din,
        input  grant, grant_idx, dout, dout_valid, busy
    );

    modport slave (
        input  req, din,
        output grant, grant_idx, dout, dout_valid, busy
    );
endinterface

// File: rtl/bus_share_arbiter.sv
// Round-robin owner select for one shared SIZE-bit bus; bursts are
// capped at MAX_BURST and every ownership ends with one idle bubble.
module bus_share_arbiter #(
    parameter int SIZE      = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input logic                clk,
    input logic                rst,
    bus_share_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] dout_q;
    logic            valid_q;
    logic            busy_q;

    logic [IW-1:0]   win_d;
    logic            any_d;
    logic [IW:0]     scan_sum;
    logic [NREQ-1:0] win_oh_d;
    logic [IW-1:0]   ptr_d;
    logic            own_req;
    logic [SIZE-1:0] own_din;

    // Scan downward so the smallest offset from ptr is the last to win.
    always_comb begin
        win_d    = '0;
        any_d    = 1'b0;
        scan_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr_q} + (IW + 1)'(k);
            if (scan_sum >= (IW + 1)'(NREQ)) begin
                scan_sum = scan_sum - (IW + 1)'(NREQ);
            end
            if (bus.req[scan_sum[IW-1:0]]) begin
                win_d = scan_sum[IW-1:0];
                any_d = 1'b1;
            end
        end
    end

    assign win_oh_d = {{(NREQ - 1){1'b0}}, 1'b1} << win_d;
    assign ptr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    assign own_req  = bus.req[idx_q];
    assign own_din  = bus.din[idx_q*SIZE +: SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (any_d) begin
                        grant_q <= win_oh_d;
                        idx_q   <= win_d;
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_req) begin
                        dout_q  <= own_din;
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                    if (own_req && (cnt_q < CW'(MAX_BURST))) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_idx  = idx_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule
